// File: rtl/seq_alu.sv
// Bit-serial WIDTH-bit logic ALU: latches opcode and operands on start, evaluates
// one result bit per clock LSB first, then publishes F, a one-hot class and zero.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             M,
  input  logic             S1,
  input  logic             S0,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic [WIDTH-1:0] F,
  output logic [5:0]       cls,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [5:0]       cls_q, cls_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             bit_now;
  logic [WIDTH-1:0] result;

  function automatic logic op_bit(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'b000, 3'b100: op_bit = a;
      3'b001, 3'b101: op_bit = ~a;
      3'b010:         op_bit = a ^ b;
      3'b011:         op_bit = ~(a ^ b);
      3'b110:         op_bit = a | b;
      default:        op_bit = ~a | b;
    endcase
  endfunction

  function automatic logic [5:0] op_class(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: op_class = 6'b000001;
      3'b001, 3'b101: op_class = 6'b000010;
      3'b010:         op_class = 6'b000100;
      3'b011:         op_class = 6'b001000;
      3'b110:         op_class = 6'b010000;
      default:        op_class = 6'b100000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    cls_d   = cls_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    bit_now = op_bit(op_q, a_q[cnt_q], b_q[cnt_q]);
    // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
    result  = {bit_now, sh_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = {M, S1, S0};
          a_d     = A;
          b_d     = B;
          sh_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sh_d = result[WIDTH-1:1];
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          f_d     = result;
          cls_d   = op_class(op_q);
          zero_d  = (result == '0);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and published outputs take reset; operand/shift storage does not need it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f_q     <= '0;
      cls_q   <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      cls_q   <= cls_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
    sh_q <= sh_d;
  end

  assign F    = f_q;
  assign cls  = cls_q;
  assign zero = zero_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule
